// File: rtl/issue_scoreboard.sv
// issue_scoreboard: tracks in-flight register writes of the in-order pipeline
// and refuses issue of any instruction that would read a pending destination.
`timescale 1ns/1ps
module issue_scoreboard #(
  parameter int unsigned STAGES               = 3,
  parameter bit          BYPASS               = 1'b1,
  parameter bit          R0_HAZARD            = 1'b0,
  parameter logic [4:0]  INSTR_ALU_OP         = 5'd1,
  parameter logic [4:0]  INSTR_LOAD           = 5'd2,
  parameter logic [4:0]  INSTR_LOAD_IMMEDIATE = 5'd3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        issue_valid,
  input  logic [31:0] issue_instr,
  input  logic [4:0]  src_a,
  input  logic [4:0]  src_b,
  input  logic        src_a_en,
  input  logic        src_b_en,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_reg,
  output logic [31:0] pending_mask,
  output logic [3:0]  pending_count
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 4;
  localparam int          LAST  = int'(STAGES) - 1;

  // In-flight pipe: entry 0 is the newest write, entry LAST is retiring.
  logic [STAGES-1:0]            valid_q, valid_d;
  logic [STAGES-1:0][REG_W-1:0] reg_q, reg_d;

  logic [REG_W-1:0] dest_c;
  logic             writes_c;
  logic             hit_a_c, hit_b_c;
  logic             load_c;

  // Instruction bits that carry no destination information here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{issue_instr[26:22], issue_instr[11], issue_instr[5:0]};

  // Destination decode, matching the decode stage's instruction-type rules.
  always_comb begin
    dest_c   = '0;
    writes_c = 1'b0;
    case (issue_instr[31:27])
      INSTR_ALU_OP: begin
        writes_c = 1'b1;
        dest_c   = issue_instr[16:12];
      end
      INSTR_LOAD: begin
        writes_c = 1'b1;
        dest_c   = issue_instr[21:17];
      end
      INSTR_LOAD_IMMEDIATE: begin
        writes_c = 1'b1;
        dest_c   = issue_instr[10:6];
      end
      default: begin
        writes_c = 1'b0;
        dest_c   = '0;
      end
    endcase
  end

  // RAW hazard search; the retiring entry is skipped when it can be bypassed.
  always_comb begin
    hit_a_c = 1'b0;
    hit_b_c = 1'b0;
    for (int i = 0; i < int'(STAGES); i++) begin
      if (valid_q[i] && ((i < LAST) || !BYPASS)) begin
        if (reg_q[i] == src_a) hit_a_c = 1'b1;
        if (reg_q[i] == src_b) hit_b_c = 1'b1;
      end
    end
    hit_a_c = hit_a_c & src_a_en & ((src_a != '0) | R0_HAZARD);
    hit_b_c = hit_b_c & src_b_en & ((src_b != '0) | R0_HAZARD);
  end

  assign stall  = issue_valid & (hit_a_c | hit_b_c);
  assign load_c = issue_valid & ~stall & writes_c & ((dest_c != '0) | R0_HAZARD);

  // Next pipe state: shift every cycle, new write or bubble into entry 0, flush clears.
  always_comb begin
    valid_d = '0;
    reg_d   = '0;
    if (!flush) begin
      for (int i = 1; i < int'(STAGES); i++) begin
        valid_d[i] = valid_q[i-1];
        reg_d[i]   = reg_q[i-1];
      end
      if (load_c) begin
        valid_d[0] = 1'b1;
        reg_d[0]   = dest_c;
      end
    end
  end

  // Pipe registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      reg_q   <= '0;
    end else begin
      valid_q <= valid_d;
      reg_q   <= reg_d;
    end
  end

  assign wb_valid = valid_q[LAST];
  assign wb_reg   = reg_q[LAST];

  // Debug views: destinations pending (duplicates once) and valid-entry count.
  always_comb begin
    pending_mask  = '0;
    pending_count = '0;
    for (int i = 0; i < int'(STAGES); i++) begin
      if (valid_q[i]) begin
        pending_mask[reg_q[i]] = 1'b1;
        pending_count          = pending_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: two scoreboards (BYPASS=1 and BYPASS=0, STAGES=3) on
// shared stimulus; retiring writes are matched against a queue of expectations.
`timescale 1ns/1ps
module tb_issue_scoreboard;

  localparam int         STG   = 3;
  localparam logic [4:0] T_ALU = 5'd1;
  localparam logic [4:0] T_LD  = 5'd2;
  localparam logic [4:0] T_LDI = 5'd3;
  localparam logic [4:0] T_NW  = 5'd7;

  logic        clk = 1'b0;
  logic        rst_n, flush, issue_valid;
  logic [31:0] issue_instr;
  logic [4:0]  src_a, src_b;
  logic        src_a_en, src_b_en;

  logic        stall_a, wb_valid_a, stall_b, wb_valid_b;
  logic [4:0]  wb_reg_a, wb_reg_b;
  logic [31:0] mask_a, mask_b;
  logic [3:0]  count_a, count_b;

  typedef struct {
    int         due;
    logic [4:0] rg;
  } wb_exp_t;

  wb_exp_t qa[$];
  wb_exp_t qb[$];
  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  issue_scoreboard #(.STAGES(STG), .BYPASS(1'b1), .R0_HAZARD(1'b0),
    .INSTR_ALU_OP(T_ALU), .INSTR_LOAD(T_LD), .INSTR_LOAD_IMMEDIATE(T_LDI)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .issue_valid(issue_valid),
    .issue_instr(issue_instr), .src_a(src_a), .src_b(src_b),
    .src_a_en(src_a_en), .src_b_en(src_b_en), .stall(stall_a),
    .wb_valid(wb_valid_a), .wb_reg(wb_reg_a), .pending_mask(mask_a),
    .pending_count(count_a));

  issue_scoreboard #(.STAGES(STG), .BYPASS(1'b0), .R0_HAZARD(1'b0),
    .INSTR_ALU_OP(T_ALU), .INSTR_LOAD(T_LD), .INSTR_LOAD_IMMEDIATE(T_LDI)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .issue_valid(issue_valid),
    .issue_instr(issue_instr), .src_a(src_a), .src_b(src_b),
    .src_a_en(src_a_en), .src_b_en(src_b_en), .stall(stall_b),
    .wb_valid(wb_valid_b), .wb_reg(wb_reg_b), .pending_mask(mask_b),
    .pending_count(count_b));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Retire monitor: each observed writeback must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wb_valid_a) begin
        if (qa.size() == 0) check("a_wb_spurious", 32'(wb_valid_a), 32'd0);
        else begin
          check("a_wb_reg", 32'(wb_reg_a), 32'(qa[0].rg));
          check("a_wb_cycle", 32'(cyc), 32'(qa[0].due));
          void'(qa.pop_front());
        end
      end else if (qa.size() != 0 && qa[0].due == cyc) begin
        check("a_wb_missing", 32'(wb_valid_a), 32'd1);
        void'(qa.pop_front());
      end
      if (wb_valid_b) begin
        if (qb.size() == 0) check("b_wb_spurious", 32'(wb_valid_b), 32'd0);
        else begin
          check("b_wb_reg", 32'(wb_reg_b), 32'(qb[0].rg));
          check("b_wb_cycle", 32'(cyc), 32'(qb[0].due));
          void'(qb.pop_front());
        end
      end else if (qb.size() != 0 && qb[0].due == cyc) begin
        check("b_wb_missing", 32'(wb_valid_b), 32'd1);
        void'(qb.pop_front());
      end
    end
  end

  function automatic logic [31:0] mk(input logic [4:0] ty, input logic [4:0] f16,
                                     input logic [4:0] f21, input logic [4:0] f10);
    logic [31:0] w;
    w        = 32'h0;
    w[31:27] = ty;
    w[26:22] = 5'h15;
    w[21:17] = f21;
    w[16:12] = f16;
    w[11]    = 1'b1;
    w[10:6]  = f10;
    w[5:0]   = 6'h2a;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    issue_instr = 32'h0;
    flush       = 1'b0;
    src_a       = 5'd0;
    src_b       = 5'd0;
    src_a_en    = 1'b0;
    src_b_en    = 1'b0;
  endtask

  task automatic put(input logic [31:0] ins, input logic [4:0] sa, input logic sae,
                     input logic [4:0] sb, input logic sbe);
    issue_valid = 1'b1;
    issue_instr = ins;
    flush       = 1'b0;
    src_a       = sa;
    src_a_en    = sae;
    src_b       = sb;
    src_b_en    = sbe;
  endtask

  task automatic expect_wb(input logic [4:0] r);
    qa.push_back('{due: cyc + STG, rg: r});
    qb.push_back('{due: cyc + STG, rg: r});
  endtask

  task automatic drain();
    idle();
    repeat (STG + 1) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] occ_dst [4];
    logic [3:0] occ_cnt [7];
    occ_dst = '{5'd20, 5'd21, 5'd22, 5'd20};
    occ_cnt = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd2, 4'd1, 4'd0};

    // Reset and idle.
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    check("rst_wb_valid", 32'(wb_valid_a), 32'd0);
    check("rst_wb_reg", 32'(wb_reg_a), 32'd0);
    check("rst_mask", mask_a, 32'd0);
    check("rst_count", 32'(count_a), 32'd0);
    check("rst_stall", 32'(stall_a), 32'd0);
    check("rst_count_b", 32'(count_b), 32'd0);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("idle_stall", 32'(stall_a), 32'd0);
      check("idle_mask", mask_a, 32'd0);
      check("idle_count", 32'(count_a), 32'd0);
      check("idle_wb_valid", 32'(wb_valid_a), 32'd0);
    end

    // Basic retire of an ALU write to r5.
    tick();
    put(mk(T_ALU, 5'd5, 5'd9, 5'd11), 5'd0, 1'b0, 5'd0, 1'b0);
    expect_wb(5'd5);
    #1 check("basic_stall", 32'(stall_a), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      idle();
      check("basic_mask", mask_a, 32'h20);
      check("basic_mask_b", mask_b, 32'h20);
    end
    check("basic_wb_valid", 32'(wb_valid_a), 32'd1);
    check("basic_wb_reg", 32'(wb_reg_a), 32'd5);
    tick();
    check("basic_mask_end", mask_a, 32'd0);
    check("basic_count_end", 32'(count_a), 32'd0);
    drain();

    // RAW stall on src_a: BYPASS=1 releases at t=3, BYPASS=0 at t=4.
    tick();
    put(mk(T_ALU, 5'd7, 5'd0, 5'd0), 5'd0, 1'b0, 5'd0, 1'b0);
    expect_wb(5'd7);
    tick();
    put(mk(T_NW, 5'd7, 5'd7, 5'd7), 5'd7, 1'b1, 5'd0, 1'b0);
    #1;
    check("raw_t1_a", 32'(stall_a), 32'd1);
    check("raw_t1_b", 32'(stall_b), 32'd1);
    tick();
    check("raw_t2_a", 32'(stall_a), 32'd1);
    check("raw_t2_b", 32'(stall_b), 32'd1);
    tick();
    check("raw_t3_a", 32'(stall_a), 32'd0);
    check("raw_t3_b", 32'(stall_b), 32'd1);
    tick();
    check("raw_t4_a", 32'(stall_a), 32'd0);
    check("raw_t4_b", 32'(stall_b), 32'd0);
    drain();

    // Destination decode by type and the r0 rules.
    tick();
    put(mk(T_LD, 5'd3, 5'd9, 5'd4), 5'd0, 1'b0, 5'd0, 1'b0);
    expect_wb(5'd9);
    tick();
    check("ld_mask", mask_a, 32'h200);
    check("ld_count", 32'(count_a), 32'd1);
    put(mk(T_LDI, 5'd5, 5'd6, 5'd12), 5'd0, 1'b0, 5'd0, 1'b0);
    expect_wb(5'd12);
    tick();
    check("ldi_mask", mask_a, 32'h1200);
    check("ldi_count", 32'(count_a), 32'd2);
    put(mk(T_NW, 5'd13, 5'd14, 5'd15), 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    check("nw_count", 32'(count_a), 32'd2);
    put(mk(T_ALU, 5'd0, 5'd8, 5'd10), 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    check("r0_dest_count", 32'(count_a), 32'd1);
    check("r0_dest_mask", mask_a, 32'h1000);
    put(mk(T_NW, 5'd0, 5'd0, 5'd0), 5'd0, 1'b1, 5'd0, 1'b1);
    #1;
    check("r0_src_stall_a", 32'(stall_a), 32'd0);
    check("r0_src_stall_b", 32'(stall_b), 32'd0);
    tick();
    idle();
    tick();
    check("decode_count_end", 32'(count_a), 32'd0);
    drain();

    // src_b hazard and source-enable gating.
    tick();
    put(mk(T_ALU, 5'd11, 5'd0, 5'd0), 5'd0, 1'b0, 5'd0, 1'b0);
    expect_wb(5'd11);
    tick();
    put(mk(T_NW, 5'd0, 5'd0, 5'd0), 5'd11, 1'b0, 5'd0, 1'b1);
    #1;
    check("en_gate_a", 32'(stall_a), 32'd0);
    check("en_gate_b", 32'(stall_b), 32'd0);
    tick();
    put(mk(T_NW, 5'd0, 5'd0, 5'd0), 5'd0, 1'b0, 5'd11, 1'b1);
    #1;
    check("srcb_stall_a", 32'(stall_a), 32'd1);
    check("srcb_stall_b", 32'(stall_b), 32'd1);
    drain();

    // Flush with three writes in flight; the flush-cycle issue is discarded.
    for (int k = 1; k <= 3; k++) begin
      tick();
      put(mk(T_ALU, 5'(k), 5'd0, 5'd0), 5'd0, 1'b0, 5'd0, 1'b0);
      expect_wb(5'(k));
    end
    tick();
    check("pre_flush_mask", mask_a, 32'h0e);
    check("pre_flush_count", 32'(count_a), 32'd3);
    put(mk(T_ALU, 5'd4, 5'd0, 5'd0), 5'd0, 1'b0, 5'd0, 1'b0);
    flush = 1'b1;
    tick();
    idle();
    qa.delete();
    qb.delete();
    check("flush_mask", mask_a, 32'd0);
    check("flush_count", 32'(count_a), 32'd0);
    check("flush_wb_valid", 32'(wb_valid_a), 32'd0);
    check("flush_mask_b", mask_b, 32'd0);
    drain();

    // Asynchronous reset mid-flight with a stalled consumer present.
    for (int k = 1; k <= 3; k++) begin
      tick();
      put(mk(T_ALU, 5'(k), 5'd0, 5'd0), 5'd0, 1'b0, 5'd0, 1'b0);
      expect_wb(5'(k));
    end
    tick();
    put(mk(T_NW, 5'd0, 5'd0, 5'd0), 5'd3, 1'b1, 5'd0, 1'b0);
    #1 check("pre_rst_stall", 32'(stall_a), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    qa.delete();
    qb.delete();
    check("arst_mask", mask_a, 32'd0);
    check("arst_count", 32'(count_a), 32'd0);
    check("arst_wb_valid", 32'(wb_valid_a), 32'd0);
    check("arst_stall_a", 32'(stall_a), 32'd0);
    check("arst_stall_b", 32'(stall_b), 32'd0);
    idle();
    tick();
    #3 rst_n = 1'b1;
    drain();

    // Back-to-back occupancy; the 4th write reuses the 1st destination.
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k >= 1) begin
        check("occ_count", 32'(count_a), 32'(occ_cnt[k-1]));
        check("occ_r20_bit", 32'(mask_a[20]), (k <= 6) ? 32'd1 : 32'd0);
      end
      if (k == 4) check("occ_mask_t4", mask_a, 32'h0070_0000);
      if (k < 4) begin
        put(mk(T_ALU, occ_dst[k], 5'd0, 5'd0), 5'd0, 1'b0, 5'd0, 1'b0);
        expect_wb(occ_dst[k]);
      end else idle();
    end

    // Duplicate destinations in flight together.
    tick();
    put(mk(T_ALU, 5'd25, 5'd0, 5'd0), 5'd0, 1'b0, 5'd0, 1'b0);
    expect_wb(5'd25);
    tick();
    expect_wb(5'd25);
    tick();
    idle();
    check("dup_mask", mask_a, 32'h0200_0000);
    check("dup_count", 32'(count_a), 32'd2);
    drain();
    tick();

    check("a_queue_drained", 32'(qa.size()), 32'd0);
    check("b_queue_drained", 32'(qb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
